// File: rtl/ni_route_lookup_ctrl_if.sv
// rtl/ni_route_lookup_ctrl_if.sv - request, LUT and descriptor bundle for the route lookup controller
interface ni_route_lookup_ctrl_if #(
    parameter int ADDR_WIDTH   = 32,
    parameter int PATH_WIDTH   = 7,
    parameter int TGT_WIDTH    = 4,
    parameter int ID_WIDTH     = 4,
    parameter int ERRCNT_WIDTH = 8
) ();
    // write request channel
    logic                    wr_req_valid;
    logic [ADDR_WIDTH-1:0]   wr_req_addr;
    logic [ID_WIDTH-1:0]     wr_req_id;
    logic                    wr_req_ready;
    // read request channel
    logic                    rd_req_valid;
    logic [ADDR_WIDTH-1:0]   rd_req_addr;
    logic [ID_WIDTH-1:0]     rd_req_id;
    logic                    rd_req_ready;
    // shared combinational routing LUT
    logic [ADDR_WIDTH-1:0]   lut_address;
    logic [PATH_WIDTH-1:0]   lut_path;
    logic [TGT_WIDTH-1:0]    transaction_target;
    logic                    failed_decoding;
    // header descriptor to the packetizer
    logic                    hdr_valid;
    logic                    hdr_ready;
    logic [PATH_WIDTH-1:0]   hdr_path;
    logic [TGT_WIDTH-1:0]    hdr_target;
    logic [ID_WIDTH-1:0]     hdr_id;
    logic                    hdr_is_write;
    // error descriptor to the local response path
    logic                    err_valid;
    logic                    err_ready;
    logic [ID_WIDTH-1:0]     err_id;
    logic                    err_is_write;
    // status
    logic [ERRCNT_WIDTH-1:0] err_count;
    logic                    busy;

    // controller side
    modport master (
        input  wr_req_valid, wr_req_addr, wr_req_id,
        output wr_req_ready,
        input  rd_req_valid, rd_req_addr, rd_req_id,
        output rd_req_ready,
        output lut_address,
        input  lut_path, transaction_target, failed_decoding,
        output hdr_valid, hdr_path, hdr_target, hdr_id, hdr_is_write,
        input  hdr_ready,
        output err_valid, err_id, err_is_write,
        input  err_ready,
        output err_count, busy
    );

    // requesters, LUT and consumers
    modport slave (
        output wr_req_valid, wr_req_addr, wr_req_id,
        input  wr_req_ready,
        output rd_req_valid, rd_req_addr, rd_req_id,
        input  rd_req_ready,
        input  lut_address,
        output lut_path, transaction_target, failed_decoding,
        input  hdr_valid, hdr_path, hdr_target, hdr_id, hdr_is_write,
        output hdr_ready,
        input  err_valid, err_id, err_is_write,
        output err_ready,
        input  err_count, busy
    );
endinterface

// File: rtl/ni_route_lookup_ctrl.sv
// rtl/ni_route_lookup_ctrl.sv - round-robin shared routing LUT sequencer for the NI initiator
module ni_route_lookup_ctrl #(
    parameter int ADDR_WIDTH   = 32,
    parameter int PATH_WIDTH   = 7,
    parameter int TGT_WIDTH    = 4,
    parameter int ID_WIDTH     = 4,
    parameter int ERRCNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    ni_route_lookup_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOOKUP   = 2'd1,
        SEND_HDR = 2'd2,
        SEND_ERR = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    // ptr_rd = 1 means the read channel wins the next tie
    logic                    ptr_rd;
    logic                    grant_wr;
    logic                    grant_rd;

    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [ID_WIDTH-1:0]     req_id;
    logic                    req_is_write;

    logic [PATH_WIDTH-1:0]   hdr_path_q;
    logic [TGT_WIDTH-1:0]    hdr_target_q;
    logic [ID_WIDTH-1:0]     hdr_id_q;
    logic                    hdr_is_write_q;
    logic [ID_WIDTH-1:0]     err_id_q;
    logic                    err_is_write_q;
    logic [ERRCNT_WIDTH-1:0] err_count_q;

    // next-state and grant decode; grants exist only in IDLE
    always_comb begin
        state_nxt = state;
        grant_wr  = 1'b0;
        grant_rd  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.wr_req_valid && (!bus.rd_req_valid || !ptr_rd)) begin
                    grant_wr = 1'b1;
                end else if (bus.rd_req_valid) begin
                    grant_rd = 1'b1;
                end
                if (grant_wr || grant_rd) begin
                    state_nxt = LOOKUP;
                end
            end
            LOOKUP: begin
                state_nxt = bus.failed_decoding ? SEND_ERR : SEND_HDR;
            end
            SEND_HDR: begin
                if (bus.hdr_ready) begin
                    state_nxt = IDLE;
                end
            end
            SEND_ERR: begin
                if (bus.err_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // request capture, LUT result capture and decode-failure counter
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_rd         <= 1'b0;
            req_addr       <= '0;
            req_id         <= '0;
            req_is_write   <= 1'b0;
            hdr_path_q     <= '0;
            hdr_target_q   <= '0;
            hdr_id_q       <= '0;
            hdr_is_write_q <= 1'b0;
            err_id_q       <= '0;
            err_is_write_q <= 1'b0;
            err_count_q    <= '0;
        end else begin
            if (grant_wr || grant_rd) begin
                req_addr     <= grant_wr ? bus.wr_req_addr : bus.rd_req_addr;
                req_id       <= grant_wr ? bus.wr_req_id : bus.rd_req_id;
                req_is_write <= grant_wr;
                // favour the channel that was not just served
                ptr_rd       <= grant_wr;
            end
            // descriptor registers only change when a new descriptor is
            // formed, so they hold their previous values while not valid
            if (state == LOOKUP) begin
                if (bus.failed_decoding) begin
                    err_id_q       <= req_id;
                    err_is_write_q <= req_is_write;
                    if (!(&err_count_q)) begin
                        err_count_q <= err_count_q + ERRCNT_WIDTH'(1);
                    end
                end else begin
                    hdr_path_q     <= bus.lut_path;
                    hdr_target_q   <= bus.transaction_target;
                    hdr_id_q       <= req_id;
                    hdr_is_write_q <= req_is_write;
                end
            end
        end
    end

    assign bus.wr_req_ready = grant_wr;
    assign bus.rd_req_ready = grant_rd;
    assign bus.lut_address  = req_addr;
    assign bus.hdr_valid    = (state == SEND_HDR);
    assign bus.hdr_path     = hdr_path_q;
    assign bus.hdr_target   = hdr_target_q;
    assign bus.hdr_id       = hdr_id_q;
    assign bus.hdr_is_write = hdr_is_write_q;
    assign bus.err_valid    = (state == SEND_ERR);
    assign bus.err_id       = err_id_q;
    assign bus.err_is_write = err_is_write_q;
    assign bus.err_count    = err_count_q;
    assign bus.busy         = (state != IDLE);

endmodule

// File: tb/tb_ni_route_lookup_ctrl.sv
// tb/tb_ni_route_lookup_ctrl.sv - directed and randomized checks of ni_route_lookup_ctrl
module tb_ni_route_lookup_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int total = 0;
    int bad   = 0;

    // reference state: which channel wins a tie, and expected miss count
    bit ptr_wr   = 1'b1;
    int exp_errs = 0;

    ni_route_lookup_ctrl_if bus ();

    ni_route_lookup_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // cluster routing table: {miss, path[6:0], target[3:0]}
    function automatic logic [11:0] lut_fn(input logic [31:0] a);
        logic [11:0] r;
        case (a[31:20])
            12'h100: r = {1'b0, 7'b0000000, 4'h1};
            12'h108: r = {1'b0, 7'b0000011, 4'h8};
            12'h10c: r = {1'b0, 7'b0000010, 4'hb};
            12'h1a0: r = {1'b0, 7'b0000111, 4'hc};
            default: begin
                if (a[31:28] == 4'h1) r = {1'b0, a[26:20], a[23:20] ^ 4'h5};
                else                  r = {1'b1, 7'd0, 4'h0};
            end
        endcase
        return r;
    endfunction

    logic [11:0] lut_res;
    always_comb begin
        lut_res                = lut_fn(bus.lut_address);
        bus.failed_decoding    = lut_res[11];
        bus.lut_path           = lut_res[10:4];
        bus.transaction_target = lut_res[3:0];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 6))
            0: return 32'h1000_0000;
            1: return 32'h1080_0000;
            2: return 32'h10c0_0010;
            3: return 32'h1a00_0000;
            4: return 32'h2000_0000;
            5: return {4'h1, 28'($urandom)};
            default: return $urandom;
        endcase
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.wr_req_valid = 1'b0;
        bus.rd_req_valid = 1'b0;
        bus.hdr_ready    = 1'b0;
        bus.err_ready    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        ptr_wr   = 1'b1;
        exp_errs = 0;
        #1;
        check("rst_hdr_valid", bus.hdr_valid, 0);
        check("rst_err_valid", bus.err_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_err_count", bus.err_count, 0);
        check("rst_lut_address", bus.lut_address, 0);
        check("rst_hdr_path", bus.hdr_path, 0);
        check("rst_hdr_id", bus.hdr_id, 0);
    endtask

    // one request round: offer, expect grant, LUT cycle, descriptor with d stall cycles
    task automatic txn(input bit wv, input logic [31:0] wa, input logic [3:0] wi,
                       input bit rv, input logic [31:0] ra, input logic [3:0] ri,
                       input int d);
        bit          exp_w, exp_r, isw, miss;
        logic [31:0] a;
        logic [3:0]  id;
        logic [11:0] r;
        @(negedge clk);
        bus.wr_req_valid = wv; bus.wr_req_addr = wa; bus.wr_req_id = wi;
        bus.rd_req_valid = rv; bus.rd_req_addr = ra; bus.rd_req_id = ri;
        #1;
        exp_w = wv && (!rv || ptr_wr);
        exp_r = rv && !exp_w;
        check("grant_wr_ready", bus.wr_req_ready, exp_w);
        check("grant_rd_ready", bus.rd_req_ready, exp_r);
        check("grant_busy", bus.busy, 0);
        isw  = exp_w;
        a    = exp_w ? wa : ra;
        id   = exp_w ? wi : ri;
        r    = lut_fn(a);
        miss = r[11];
        ptr_wr = !exp_w;
        // cycle 1: lookup
        @(negedge clk);
        if (exp_w) bus.wr_req_valid = 1'b0; else bus.rd_req_valid = 1'b0;
        #1;
        check("lk_busy", bus.busy, 1);
        check("lk_wr_ready", bus.wr_req_ready, 0);
        check("lk_rd_ready", bus.rd_req_ready, 0);
        check("lk_lut_address", bus.lut_address, a);
        check("lk_hdr_valid", bus.hdr_valid, 0);
        check("lk_err_valid", bus.err_valid, 0);
        // cycle 2 onward: descriptor
        if (miss) exp_errs = (exp_errs < 255) ? exp_errs + 1 : 255;
        for (int k = 0; k <= d; k++) begin
            @(negedge clk);
            #1;
            check("ds_hdr_valid", bus.hdr_valid, !miss);
            check("ds_err_valid", bus.err_valid, miss);
            check("ds_wr_ready", bus.wr_req_ready, 0);
            check("ds_rd_ready", bus.rd_req_ready, 0);
            check("ds_err_count", bus.err_count, exp_errs);
            if (miss) begin
                check("ds_err_id", bus.err_id, id);
                check("ds_err_is_write", bus.err_is_write, isw);
            end else begin
                check("ds_hdr_path", bus.hdr_path, r[10:4]);
                check("ds_hdr_target", bus.hdr_target, r[3:0]);
                check("ds_hdr_id", bus.hdr_id, id);
                check("ds_hdr_is_write", bus.hdr_is_write, isw);
            end
            // the wrong ready is random and must be ignored
            if (miss) begin
                bus.err_ready = (k == d);
                bus.hdr_ready = 1'($urandom_range(0, 1));
            end else begin
                bus.hdr_ready = (k == d);
                bus.err_ready = 1'($urandom_range(0, 1));
            end
        end
        @(negedge clk);
        #1;
        check("done_busy", bus.busy, 0);
        check("done_hdr_valid", bus.hdr_valid, 0);
        check("done_err_valid", bus.err_valid, 0);
        // a still-pending loser is now the only candidate and must see ready
        check("done_loser_wr_ready", bus.wr_req_ready, bus.wr_req_valid);
        check("done_loser_rd_ready", bus.rd_req_ready, bus.rd_req_valid);
        bus.wr_req_valid = 1'b0;
        bus.rd_req_valid = 1'b0;
        bus.hdr_ready    = 1'b0;
        bus.err_ready    = 1'b0;
    endtask

    initial begin
        bus.wr_req_valid = 1'b0; bus.wr_req_addr = '0; bus.wr_req_id = '0;
        bus.rd_req_valid = 1'b0; bus.rd_req_addr = '0; bus.rd_req_id = '0;
        bus.hdr_ready    = 1'b0; bus.err_ready   = 1'b0;

        do_reset();

        // single write hit
        txn(1'b1, 32'h1000_0000, 4'h2, 1'b0, 32'h0, 4'h0, 0);

        // tie from reset: write first, then read
        do_reset();
        txn(1'b1, 32'h1a00_0000, 4'h5, 1'b1, 32'h10c0_0010, 4'h3, 0);
        check("tie_hdr_path_wr", bus.hdr_path, 7'b0000111);
        check("tie_hdr_target_wr", bus.hdr_target, 4'hc);
        txn(1'b0, 32'h0, 4'h0, 1'b1, 32'h10c0_0010, 4'h3, 0);
        check("tie_hdr_path_rd", bus.hdr_path, 7'b0000010);
        check("tie_hdr_target_rd", bus.hdr_target, 4'hb);
        check("tie_hdr_id_rd", bus.hdr_id, 4'h3);

        // backpressure for 5 cycles
        txn(1'b0, 32'h0, 4'h0, 1'b1, 32'h1080_0000, 4'h7, 5);
        check("bp_hdr_path", bus.hdr_path, 7'b0000011);
        check("bp_hdr_target", bus.hdr_target, 4'h8);

        // decode miss
        check("miss_err_count_before", bus.err_count, 0);
        txn(1'b1, 32'h2000_0000, 4'h9, 1'b0, 32'h0, 4'h0, 0);
        check("miss_err_count_after", bus.err_count, 1);

        // saturation
        do_reset();
        for (int i = 0; i < 260; i++) begin
            txn(i[0], 32'h2000_0000, 4'(i), !i[0], 32'h3000_0000, 4'(i + 1), 0);
        end
        check("sat_err_count", bus.err_count, 8'hff);
        do_reset();

        // reset while a header is stalled
        txn(1'b1, 32'h4000_0000, 4'h1, 1'b0, 32'h0, 4'h0, 0);
        @(negedge clk);
        bus.wr_req_valid = 1'b1; bus.wr_req_addr = 32'h1000_0000; bus.wr_req_id = 4'h6;
        @(negedge clk);
        bus.wr_req_valid = 1'b0;
        @(negedge clk);
        #1;
        check("mid_hdr_valid_before", bus.hdr_valid, 1);
        check("mid_err_count_before", bus.err_count, 1);
        bus.hdr_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ptr_wr   = 1'b1;
        exp_errs = 0;
        #1;
        check("mid_hdr_valid", bus.hdr_valid, 0);
        check("mid_busy", bus.busy, 0);
        check("mid_err_count", bus.err_count, 0);
        txn(1'b1, 32'h1a00_0000, 4'h4, 1'b1, 32'h1080_0000, 4'h6, 0);
        check("mid_grant_is_write", bus.hdr_is_write, 1);

        // randomized rounds
        for (int i = 0; i < 200; i++) begin
            bit wv, rv;
            wv = 1'($urandom_range(0, 1));
            rv = wv ? 1'($urandom_range(0, 1)) : 1'b1;
            txn(wv, pick_addr(), 4'($urandom), rv, pick_addr(), 4'($urandom),
                int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // watchdog
    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ni_route_lookup_ctrl.md
Name: ni_route_lookup_ctrl

Overview:
- Front-end sequencer in the NI initiator; shares one combinational routing LUT between the write-request and read-request channels.
- Arbitrates the two channels round-robin and drives the LUT address from a registered request.
- Captures route, target and decode status, then issues either a header descriptor to the packetizer or an error descriptor to the local response path.
- Keeps a saturating count of decode failures.

Parameters:
- ADDR_WIDTH, 32, request/LUT address width
- PATH_WIDTH, 7, LUT route field width (first hop in LSBs)
- TGT_WIDTH, 4, transaction target ID width
- ID_WIDTH, 4, transaction tag width
- ERRCNT_WIDTH, 8, decode-error counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- wr_req_valid  in  1  write request pending
- wr_req_addr  in  ADDR_WIDTH  write address
- wr_req_id  in  ID_WIDTH  write tag
- wr_req_ready  out  1  write request accepted this cycle
- rd_req_valid  in  1  read request pending
- rd_req_addr  in  ADDR_WIDTH  read address
- rd_req_id  in  ID_WIDTH  read tag
- rd_req_ready  out  1  read request accepted this cycle
- lut_address  out  ADDR_WIDTH  address to routing LUT
- lut_path  in  PATH_WIDTH  LUT route
- transaction_target  in  TGT_WIDTH  LUT target
- failed_decoding  in  1  LUT miss
- hdr_valid  out  1  header descriptor valid
- hdr_ready  in  1  packetizer accepts header
- hdr_path  out  PATH_WIDTH  registered route
- hdr_target  out  TGT_WIDTH  registered target
- hdr_id  out  ID_WIDTH  tag
- hdr_is_write  out  1  1 = write, 0 = read
- err_valid  out  1  decode-error descriptor valid
- err_ready  in  1  response path accepts error
- err_id  out  ID_WIDTH  tag of failed request
- err_is_write  out  1  type of failed request
- err_count  out  ERRCNT_WIDTH  saturating decode-failure count
- busy  out  1  state != IDLE

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high. All state updates occur on the rising edge of clk.
- Reset values:
  - State = IDLE.
  - All outputs 0, including lut_address, descriptor registers and err_count.
  - Round-robin pointer favours write.
- FSM states: IDLE, LOOKUP, SEND_HDR, SEND_ERR.
- IDLE:
  - Only one request is selected. With a single valid channel, that channel wins.
  - With both channels valid, the channel not served last wins. After reset the write channel wins.
  - The winning ready output is asserted combinationally in the same cycle, and only in IDLE. At most one ready is high.
  - On the acceptance edge: capture addr/id/type into the request registers, flip the pointer to the other channel, go to LOOKUP.
  - With no valid request, stay in IDLE.
- lut_address is driven continuously from the address register and changes only at acceptance.
- LOOKUP: one cycle of LUT settle. On the edge, register lut_path, transaction_target and failed_decoding.
  - failed_decoding = 0: go to SEND_HDR.
  - failed_decoding = 1: go to SEND_ERR and increment err_count, saturating at all-ones.
- SEND_HDR:
  - hdr_valid = 1 with stable path/target/id/type until hdr_ready is sampled high; then go to IDLE.
  - hdr_valid is deasserted in IDLE.
- SEND_ERR:
  - err_valid = 1 with stable id/type until err_ready; then go to IDLE.
  - hdr_valid stays 0 throughout.
- Latency: acceptance at cycle N gives hdr_valid/err_valid at N+2. Minimum spacing between acceptances is 3 cycles with ready held high.
- Descriptor outputs hold their last values when not valid. Consumers must use only the qualified values.
- hdr_ready or err_ready high outside their respective state is ignored.
- Requests arriving during LOOKUP or SEND_* are not accepted; requesters must hold valid and payload until ready.
- Reset mid-operation: any state returns to IDLE on the next edge. The pending descriptor is dropped, err_count is cleared and the pointer returns to write.

Test Plan:
- Cluster-1 routing table connected; single write to 0x10000000, hdr_ready = 1:
  - wr_req_ready at cycle 0.
  - hdr_valid at cycle 2 with path 7'b0000000, target 4'h1, is_write = 1.
  - Back to IDLE at cycle 3.
- Simultaneous rd 0x10c00010 (id 3) and wr 0x1a000000 (id 5) from reset:
  - Write served first, with path 7'b0000111 and target 4'hc.
  - Read served next, with path 7'b0000010, target 4'hb and hdr_id 3.
- Backpressure: read of 0x10800000 with hdr_ready low for 5 cycles:
  - hdr_valid is held high with path 7'b0000011 and target 4'h8 unchanged.
  - rd/wr ready stay 0; the header completes when hdr_ready rises.
- Decode miss: write to 0x20000000 with err_ready = 1:
  - err_valid at cycle 2 with err_is_write = 1 and the matching err_id.
  - hdr_valid is never asserted; err_count goes from 0 to 1.
- Saturation: 260 consecutive misses leave err_count = 8'hFF. A subsequent rst clears it to 0.
- Reset mid-operation: rst asserted during SEND_HDR with hdr_ready = 0:
  - Next cycle: hdr_valid = 0, busy = 0, err_count = 0.
  - With both channels valid, the next grant goes to write.
